// File: rtl/alu_seq_hs_if.sv
// Operand/result handshake bundle between the operand sequencer and the writeback stage.
interface alu_seq_hs_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       ms;
  logic [1:0]       ss;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] r_hi;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_err;

  // Upstream driver of operands and consumer of results
  modport master (
    output in_valid, a, b, ms, ss, out_ready,
    input  in_ready, out_valid, r, r_hi, flag_z, flag_n, flag_c, flag_v, flag_err
  );

  // The ALU itself
  modport slave (
    input  in_valid, a, b, ms, ss, out_ready,
    output in_ready, out_valid, r, r_hi, flag_z, flag_n, flag_c, flag_v, flag_err
  );
endinterface

// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready handshakes; single-cycle arith/logic/shift ops and
// WIDTH-iteration shift-add multiply / restoring divide. Operands are registered on
// accept (LOAD cycle), so every result is computed from local registers only.
module alu_seq_hs #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_hs_if.slave  hs
);
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_LOAD = 2'b01;
  localparam logic [1:0] S_BUSY = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  logic [1:0]       r_state, w_state_nxt;
  logic             r_in_ready, r_out_valid;
  logic [WIDTH-1:0] r_a, r_b;
  logic [1:0]       r_ms, r_ss;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc_hi, r_acc_lo;
  logic [WIDTH-1:0] r_res, r_res_hi;
  logic             r_fz, r_fn, r_fc, r_fv, r_ferr;

  logic             w_multi, w_last;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH:0]   w_sum, w_dif;
  logic [WIDTH-1:0] w_op_r, w_op_hi;
  logic             w_op_c, w_op_v, w_op_err;
  logic [WIDTH:0]   w_mul_sum, w_div_sh;
  logic [WIDTH-1:0] w_div_sub;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_acc_hi_nxt, w_acc_lo_nxt;

  // Mul, or div with non-zero divisor, needs the iterative path
  assign w_multi = (r_ms == 2'b11) && !r_ss[1] && !(r_ss[0] && (r_b == '0));
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  // State register plus registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (hs.in_valid) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = w_multi ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      default: if (hs.out_ready) w_state_nxt = S_IDLE;
    endcase
  end

  // Single-cycle result from latched operands
  always_comb begin
    w_opnd   = r_ss[1] ? WIDTH'(1) : r_b;
    w_sum    = {1'b0, r_a} + {1'b0, w_opnd};
    w_dif    = {1'b0, r_a} - {1'b0, w_opnd};
    w_op_r   = '0;
    w_op_hi  = '0;
    w_op_c   = 1'b0;
    w_op_v   = 1'b0;
    w_op_err = 1'b0;
    case (r_ms)
      2'b00: begin
        if (r_ss[0]) begin
          w_op_r = w_dif[WIDTH-1:0];
          w_op_c = w_dif[WIDTH];
          w_op_v = (r_a[WIDTH-1] != w_opnd[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
        end else begin
          w_op_r = w_sum[WIDTH-1:0];
          w_op_c = w_sum[WIDTH];
          w_op_v = (r_a[WIDTH-1] == w_opnd[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        end
      end
      2'b01: begin
        case (r_ss)
          2'b00:   w_op_r = r_a & r_b;
          2'b01:   w_op_r = r_a | r_b;
          2'b10:   w_op_r = r_a ^ r_b;
          default: w_op_r = ~r_a;
        endcase
      end
      2'b10: begin
        case (r_ss)
          2'b00:   begin w_op_r = {r_a[WIDTH-2:0], 1'b0};         w_op_c = r_a[WIDTH-1]; end
          2'b01:   begin w_op_r = {1'b0, r_a[WIDTH-1:1]};         w_op_c = r_a[0];       end
          2'b10:   begin w_op_r = {r_a[WIDTH-2:0], r_a[WIDTH-1]}; w_op_c = r_a[WIDTH-1]; end
          default: begin w_op_r = {r_a[0], r_a[WIDTH-1:1]};       w_op_c = r_a[0];       end
        endcase
      end
      default: begin
        w_op_err = 1'b1;
        if (r_ss == 2'b01) begin
          w_op_r  = '1;
          w_op_hi = r_a;
        end
      end
    endcase
  end

  // One multiply or divide iteration: hi/lo accumulator shifted as a pair
  always_comb begin
    w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : '0);
    w_div_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_div_ge  = (w_div_sh >= {1'b0, r_b});
    w_div_sub = WIDTH'(w_div_sh - {1'b0, r_b});
    if (r_ss[0]) begin
      w_acc_hi_nxt = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
      w_acc_lo_nxt = {r_acc_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_acc_hi_nxt = w_mul_sum[WIDTH:1];
      w_acc_lo_nxt = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Operand latch, iteration registers and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_ms     <= '0;
      r_ss     <= '0;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_res    <= '0;
      r_res_hi <= '0;
      r_fz     <= 1'b0;
      r_fn     <= 1'b0;
      r_fc     <= 1'b0;
      r_fv     <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hs.in_valid) begin
            r_a  <= hs.a;
            r_b  <= hs.b;
            r_ms <= hs.ms;
            r_ss <= hs.ss;
          end
        end
        S_LOAD: begin
          if (w_multi) begin
            r_acc_hi <= '0;
            r_acc_lo <= r_ss[0] ? r_a : r_b;
            r_cnt    <= '0;
          end else begin
            r_res    <= w_op_r;
            r_res_hi <= w_op_hi;
            r_fz     <= (w_op_r == '0);
            r_fn     <= w_op_r[WIDTH-1];
            r_fc     <= w_op_c;
            r_fv     <= w_op_v;
            r_ferr   <= w_op_err;
          end
        end
        S_BUSY: begin
          r_acc_hi <= w_acc_hi_nxt;
          r_acc_lo <= w_acc_lo_nxt;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_res    <= w_acc_lo_nxt;
            r_res_hi <= w_acc_hi_nxt;
            r_fz     <= (w_acc_lo_nxt == '0);
            r_fn     <= w_acc_lo_nxt[WIDTH-1];
            r_fc     <= !r_ss[0] && (w_acc_hi_nxt != '0);
            r_fv     <= 1'b0;
            r_ferr   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign hs.in_ready  = r_in_ready;
  assign hs.out_valid = r_out_valid;
  assign hs.r         = r_res;
  assign hs.r_hi      = r_res_hi;
  assign hs.flag_z    = r_fz;
  assign hs.flag_n    = r_fn;
  assign hs.flag_c    = r_fc;
  assign hs.flag_v    = r_fv;
  assign hs.flag_err  = r_ferr;
endmodule

// File: tb/tb_alu_seq_hs.sv
// Self-checking bench for alu_seq_hs (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq_hs;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] hi;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic       err;
  } res_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  alu_seq_hs_if #(.WIDTH(8)) bus ();

  alu_seq_hs #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .hs  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (got hang, want finish)");
    $fatal(1, "watchdog");
  end

  // Reference model built from the operation rules with plain integer arithmetic
  function automatic res_t model(input int a, input int b, input int ms, input int ss);
    int   res, hi, sa, so, opnd, sres, p;
    bit   c, v, err;
    res_t e;
    res = 0; hi = 0; c = 0; v = 0; err = 0;
    sa = (a >= 128) ? a - 256 : a;
    case (ms)
      0: begin
        opnd = (ss >= 2) ? 1 : b;
        so   = (opnd >= 128) ? opnd - 256 : opnd;
        if (ss % 2 == 0) begin
          res = a + opnd; c = (res > 255); sres = sa + so;
        end else begin
          res = a - opnd; c = (a < opnd); sres = sa - so;
        end
        v   = (sres > 127) || (sres < -128);
        res = res & 255;
      end
      1: begin
        case (ss)
          0: res = a & b;
          1: res = a | b;
          2: res = a ^ b;
          default: res = 255 - a;
        endcase
      end
      2: begin
        case (ss)
          0: begin res = (a * 2) % 256;           c = (a >= 128); end
          1: begin res = a / 2;                   c = (a % 2 == 1); end
          2: begin res = (a * 2) % 256 + a / 128; c = (a >= 128); end
          default: begin res = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
        endcase
      end
      default: begin
        if (ss == 0) begin
          p = a * b; res = p % 256; hi = p / 256; c = (hi != 0);
        end else if (ss == 1) begin
          if (b == 0) begin res = 255; hi = a; err = 1; end
          else begin res = a / b; hi = a % b; end
        end else begin
          err = 1;
        end
      end
    endcase
    e.r   = 8'(res);
    e.hi  = 8'(hi);
    e.z   = (res == 0);
    e.n   = (res >= 128);
    e.c   = c;
    e.v   = v;
    e.err = err;
    return e;
  endfunction

  function automatic int latency(input int b, input int ms, input int ss);
    if (ms == 3 && (ss == 0 || (ss == 1 && b != 0))) return 9;
    return 1;
  endfunction

  // One complete transaction: accept, measure latency, hold in DONE, release
  task automatic do_op(input int a, input int b, input int ms, input int ss,
                       input int hold, input bit noise);
    res_t e, got;
    int   lat, n;
    e   = model(a, b, ms, ss);
    lat = latency(b, ms, ss);
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL in_ready_idle op=%0d/%0d got=%b want=1", ms, ss, bus.in_ready);
    else n_pass++;
    bus.in_valid = 1'b1; bus.a = 8'(a); bus.b = 8'(b); bus.ms = 2'(ms); bus.ss = 2'(ss);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      if (noise && $urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b1; bus.a = 8'($urandom); bus.b = 8'($urandom);
        bus.ms = 2'($urandom); bus.ss = 2'($urandom);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n++;
    end
    n_total++;
    if (n != lat) $display("FAIL latency a=%0d b=%0d op=%0d/%0d got=%0d want=%0d", a, b, ms, ss, n, lat);
    else n_pass++;
    got = {bus.r, bus.r_hi, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_err};
    n_total++;
    if (got !== e) $display("FAIL result a=%0d b=%0d op=%0d/%0d got=%h want=%h", a, b, ms, ss, got, e);
    else n_pass++;
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        bus.in_valid = 1'b1; bus.a = 8'($urandom); bus.ms = 2'($urandom);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      got = {bus.r, bus.r_hi, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_err};
      n_total++;
      if (got !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL hold cyc=%0d got=%h ov=%b ir=%b want=%h ov=1 ir=0", h, got, bus.out_valid, bus.in_ready, e);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    res_t got;
    rst = 1'b1;
    #1;
    got = {bus.r, bus.r_hi, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_err};
    n_total++;
    if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset got=%h ov=%b ir=%b want=0 ov=0 ir=1", got, bus.out_valid, bus.in_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    for (int m = 0; m < 3; m++)
      for (int s = 0; s < 4; s++)
        do_op(10, 5, m, s, 0, 1'b0);
    do_op(11, 5, 2, 3, 0, 1'b0);
  endtask

  task automatic test_arith_corners();
    do_op(200, 100, 0, 0, 0, 1'b0);
    do_op(127, 1, 0, 0, 0, 1'b0);
    do_op(5, 10, 0, 1, 0, 1'b0);
    do_op(0, 0, 0, 3, 0, 1'b0);
    do_op(128, 1, 0, 1, 0, 1'b0);
  endtask

  task automatic test_mul_div();
    do_op(255, 255, 3, 0, 0, 1'b0);
    do_op(100, 7, 3, 1, 0, 1'b0);
    do_op(42, 0, 3, 1, 0, 1'b0);
    do_op(9, 3, 3, 2, 0, 1'b0);
    do_op(9, 3, 3, 3, 0, 1'b0);
    do_op(0, 77, 3, 0, 0, 1'b0);
    do_op(3, 200, 3, 1, 0, 1'b0);
  endtask

  task automatic test_hold();
    do_op(200, 13, 3, 0, 5, 1'b1);
    do_op(250, 6, 0, 0, 5, 1'b1);
  endtask

  task automatic test_back_to_back();
    int a, b;
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      do_op(a, b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    res_t got;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a = 8'd255; bus.b = 8'd255; bus.ms = 2'd3; bus.ss = 2'd0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    got = {bus.r, bus.r_hi, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_err};
    n_total++;
    if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL reset_mid got=%h ov=%b ir=%b want=0 ov=0 ir=1", got, bus.out_valid, bus.in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_mid_discard got ov=%b want ov=0", bus.out_valid);
    else n_pass++;
    do_op(3, 4, 0, 0, 0, 1'b0);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.ms = '0;
    bus.ss = '0;
    test_reset();
    test_sweep();
    test_arith_corners();
    test_mul_div();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
